digital_clock_hms: RTL and testbench

- Parameterised hours/minutes/seconds timekeeper; next generation of the seconds/minutes counter pair.
- Adds an internal 1 Hz prescaler, an hours field, a run/stop control and a 12/24-hour display mode.
- Adds a validated valid/ready time-set port and a day-rollover pulse.
- Sits between the system clock domain and the display/testbench; drives the `clock_if`-style counter outputs.

---
 rtl/digital_clock_hms.sv | 170 +++++++++++++++++
 tb/tb_digital_clock_hms.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_clock_hms.sv
`default_nettype none
// ============================================================================
// digital_clock_hms : HH:MM:SS timekeeper with 1 Hz prescaler, validated
//   set port and 12/24-hour display.
// Optional alarm comparator enabled by macro DIGITAL_CLOCK_ALARM_EN.
// Revision: 1.0
// ============================================================================
module digital_clock_hms #(
  parameter int TICK_DIV = 100,
  parameter int RESET_HH = 0,
  parameter int RESET_MM = 0,
  parameter int RESET_SS = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       fmt_12h,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [4:0] set_hh,
  input  logic [5:0] set_mm,
  input  logic [5:0] set_ss,
  output logic       set_err,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic       pm,
  output logic       tick_1hz,
  output logic       day_rollover
`ifdef DIGITAL_CLOCK_ALARM_EN
  ,
  input  logic       alarm_arm,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  output logic       alarm_hit
`endif
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_COUNT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [5:0]    ss;
  logic [5:0]    mm;
  logic [4:0]    hh24;

  logic          accept;
  logic          set_ok;
  logic          wrap;
  logic [5:0]    ss_nx;
  logic [5:0]    mm_nx;
  logic [4:0]    hh_nx;

  assign accept = set_valid && set_ready;
  assign set_ok = (set_hh <= 5'd23) && (set_mm <= 6'd59) && (set_ss <= 6'd59);
  assign wrap   = (state == ST_COUNT) && (prescaler == PRE_LAST);

  // Time one second ahead of the stored time, with carries.
  always_comb begin
    ss_nx = ss + 6'd1;
    mm_nx = mm;
    hh_nx = hh24;
    if (ss == 6'd59) begin
      ss_nx = 6'd0;
      mm_nx = mm + 6'd1;
      if (mm == 6'd59) begin
        mm_nx = 6'd0;
        hh_nx = (hh24 == 5'd23) ? 5'd0 : hh24 + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_STOP;
      prescaler    <= '0;
      ss           <= 6'(RESET_SS);
      mm           <= 6'(RESET_MM);
      hh24         <= 5'(RESET_HH);
      set_ready    <= 1'b1;
      set_err      <= 1'b0;
      tick_1hz     <= 1'b0;
      day_rollover <= 1'b0;
`ifdef DIGITAL_CLOCK_ALARM_EN
      alarm_hit    <= 1'b0;
`endif
    end else begin
      set_err      <= 1'b0;
      tick_1hz     <= 1'b0;
      day_rollover <= 1'b0;
`ifdef DIGITAL_CLOCK_ALARM_EN
      alarm_hit    <= 1'b0;
`endif
      case (state)
        ST_LOAD: begin
          state     <= run ? ST_COUNT : ST_STOP;
          set_ready <= 1'b1;
        end
        default: begin
          if (accept) begin
            // A set request takes priority over a coincident prescaler wrap.
            state     <= ST_LOAD;
            set_ready <= 1'b0;
            if (set_ok) begin
              ss        <= set_ss;
              mm        <= set_mm;
              hh24      <= set_hh;
              prescaler <= '0;
            end else begin
              set_err   <= 1'b1;
            end
          end else begin
            state <= run ? ST_COUNT : ST_STOP;
            if (wrap) begin
              prescaler    <= '0;
              ss           <= ss_nx;
              mm           <= mm_nx;
              hh24         <= hh_nx;
              tick_1hz     <= 1'b1;
              day_rollover <= (hh24 == 5'd23) && (mm == 6'd59) && (ss == 6'd59);
`ifdef DIGITAL_CLOCK_ALARM_EN
              alarm_hit    <= alarm_arm && (hh_nx == alarm_hh) &&
                              (mm_nx == alarm_mm) && (ss_nx == 6'd0);
`endif
            end else if (state == ST_COUNT) begin
              prescaler <= prescaler + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign seconds = ss;
  assign minutes = mm;

  // Display mapping only; the stored time stays in 24-hour encoding.
  always_comb begin
    hours = hh24;
    pm    = 1'b0;
    if (fmt_12h) begin
      if (hh24 == 5'd0) begin
        hours = 5'd12;
      end else if (hh24 > 5'd12) begin
        hours = hh24 - 5'd12;
        pm    = 1'b1;
      end else if (hh24 == 5'd12) begin
        pm    = 1'b1;
      end
    end
  end

  a_ms_range: assert property (@(posedge clk) disable iff (!rst_n)
    (seconds <= 6'd59) && (minutes <= 6'd59));

  a_hours_range: assert property (@(posedge clk) disable iff (!rst_n)
    fmt_12h ? ((hours >= 5'd1) && (hours <= 5'd12)) : (hours <= 5'd23));

  a_tick_single: assert property (@(posedge clk) disable iff (!rst_n)
    tick_1hz |=> !tick_1hz);

endmodule
`default_nettype wire

// File: tb/tb_digital_clock_hms.sv
`default_nettype none
// ============================================================================
// tb_digital_clock_hms : randomized and directed checks of digital_clock_hms
//   against a seconds-since-midnight reference model.
// Revision: 1.0
// ============================================================================
module tb_digital_clock_hms;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       fmt_12h;
  logic       set_valid;
  logic       set_ready;
  logic [4:0] set_hh;
  logic [5:0] set_mm;
  logic [5:0] set_ss;
  logic       set_err;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       pm;
  logic       tick_1hz;
  logic       day_rollover;
`ifdef DIGITAL_CLOCK_ALARM_EN
  logic       alarm_arm;
  logic [4:0] alarm_hh;
  logic [5:0] alarm_mm;
  logic       alarm_hit;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: time of day as seconds since midnight.
  int m_tod;
  int m_div;
  bit m_count;
  bit m_load;
  bit m_tick;
  bit m_roll;
  bit m_err;
  bit m_alarm;

  digital_clock_hms #(
    .TICK_DIV (TD),
    .RESET_HH (0),
    .RESET_MM (0),
    .RESET_SS (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .fmt_12h      (fmt_12h),
    .set_valid    (set_valid),
    .set_ready    (set_ready),
    .set_hh       (set_hh),
    .set_mm       (set_mm),
    .set_ss       (set_ss),
    .set_err      (set_err),
    .seconds      (seconds),
    .minutes      (minutes),
    .hours        (hours),
    .pm           (pm),
    .tick_1hz     (tick_1hz),
    .day_rollover (day_rollover)
`ifdef DIGITAL_CLOCK_ALARM_EN
    ,
    .alarm_arm    (alarm_arm),
    .alarm_hh     (alarm_hh),
    .alarm_mm     (alarm_mm),
    .alarm_hit    (alarm_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tod   = 0;
    m_div   = 0;
    m_count = 0;
    m_load  = 0;
    m_tick  = 0;
    m_roll  = 0;
    m_err   = 0;
    m_alarm = 0;
  endtask

  task automatic model_step();
    bit accept;
    m_tick  = 0;
    m_roll  = 0;
    m_err   = 0;
    m_alarm = 0;
    accept  = set_valid && !m_load;
    if (accept) begin
      m_load = 1;
      if (set_hh <= 23 && set_mm <= 59 && set_ss <= 59) begin
        m_tod = int'(set_hh) * 3600 + int'(set_mm) * 60 + int'(set_ss);
        m_div = 0;
      end else begin
        m_err = 1;
      end
    end else if (m_load) begin
      m_load  = 0;
      m_count = run;
    end else begin
      if (m_count) begin
        if (m_div == TD - 1) begin
          m_div  = 0;
          m_tod  = (m_tod + 1) % 86400;
          m_tick = 1;
          m_roll = (m_tod == 0);
`ifdef DIGITAL_CLOCK_ALARM_EN
          m_alarm = alarm_arm && (m_tod == int'(alarm_hh) * 3600 + int'(alarm_mm) * 60);
`endif
        end else begin
          m_div++;
        end
      end
      m_count = run;
    end
  endtask

  task automatic check_outputs();
    int h;
    int eh;
    h  = m_tod / 3600;
    eh = fmt_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
    check("seconds", 32'(seconds), 32'(m_tod % 60));
    check("minutes", 32'(minutes), 32'((m_tod / 60) % 60));
    check("hours", 32'(hours), 32'(eh));
    check("pm", 32'(pm), 32'(fmt_12h && h >= 12));
    check("tick_1hz", 32'(tick_1hz), 32'(m_tick));
    check("day_rollover", 32'(day_rollover), 32'(m_roll));
    check("set_err", 32'(set_err), 32'(m_err));
    check("set_ready", 32'(set_ready), 32'(!m_load));
`ifdef DIGITAL_CLOCK_ALARM_EN
    check("alarm_hit", 32'(alarm_hit), 32'(m_alarm));
`endif
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_set(input int hh, input int mm, input int ss);
    set_valid = 1'b1;
    set_hh    = 5'(hh);
    set_mm    = 6'(mm);
    set_ss    = 6'(ss);
    tick_cycle();
    set_valid = 1'b0;
  endtask

  // Returns the number of cycles until tick_1hz is seen, 0 if the bound expires.
  task automatic cycles_to_tick(input int bound, output int lat);
    lat = 0;
    for (int i = 1; i <= bound; i++) begin
      tick_cycle();
      if (tick_1hz) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int t0;
    int rolls;
    int hits;
    int fmt_hh  [4] = '{0, 12, 13, 23};
    int fmt_h12 [4] = '{12, 12, 1, 11};
    int fmt_pm  [4] = '{0, 1, 1, 1};

    rst_n     = 1'b0;
    run       = 1'b1;
    fmt_12h   = 1'b0;
    set_valid = 1'b0;
    set_hh    = '0;
    set_mm    = '0;
    set_ss    = '0;
`ifdef DIGITAL_CLOCK_ALARM_EN
    alarm_arm = 1'b0;
    alarm_hh  = '0;
    alarm_mm  = '0;
`endif
    model_reset();
    #12;
    check_outputs();

    // Reset release and first-tick latency.
    @(negedge clk);
    rst_n = 1'b1;
    cycles_to_tick(20, lat);
    check("first_tick_latency", 32'(lat), 32'd5);
    check("first_tick_seconds", 32'(seconds), 32'd1);
    cycles_to_tick(20, lat);
    check("tick_period", 32'(lat), 32'(TD));

    // Midnight rollover.
    do_set(23, 59, 58);
    rolls = 0;
    for (int i = 0; i < 12; i++) begin
      tick_cycle();
      if (day_rollover) rolls++;
    end
    check("rollover_count", 32'(rolls), 32'd1);

    // Out-of-range set request leaves the time untouched.
    t0 = m_tod;
    do_set(24, 10, 0);
    check("bad_set_err", 32'(set_err), 32'd1);
    check("bad_set_ready", 32'(set_ready), 32'd0);
    check("bad_set_time", 32'(int'(hours) * 3600 + int'(minutes) * 60 + int'(seconds)), 32'(t0));
    tick_cycle();
    check("bad_set_err_clear", 32'(set_err), 32'd0);

    // Set request landing exactly on a prescaler wrap.
    for (int i = 0; i < 20 && !(m_count && !m_load && m_div == TD - 1); i++) tick_cycle();
    check("wrap_aligned", 32'(m_div), 32'(TD - 1));
    do_set(5, 6, 7);
    check("wrap_set_no_tick", 32'(tick_1hz), 32'd0);
    check("wrap_set_seconds", 32'(seconds), 32'd7);
    // The LOAD cycle precedes the TICK_DIV counting cycles.
    cycles_to_tick(20, lat);
    check("wrap_set_latency", 32'(lat), 32'(TD + 1));
    check("wrap_set_next_sec", 32'(seconds), 32'd8);

    // 12-hour display mapping with the clock stopped.
    run = 1'b0;
    tick_cycle();
    for (int k = 0; k < 4; k++) begin
      do_set(fmt_hh[k], 34, 56);
      tick_cycle();
      fmt_12h = 1'b1;
      #1;
      check("fmt12_hours", 32'(hours), 32'(fmt_h12[k]));
      check("fmt12_pm", 32'(pm), 32'(fmt_pm[k]));
      check("fmt12_seconds", 32'(seconds), 32'd56);
      fmt_12h = 1'b0;
      #1;
      check("fmt24_hours", 32'(hours), 32'(fmt_hh[k]));
      check("fmt24_minutes", 32'(minutes), 32'd34);
      check("fmt24_seconds", 32'(seconds), 32'd56);
      @(negedge clk);
    end
    run = 1'b1;

`ifdef DIGITAL_CLOCK_ALARM_EN
    // Alarm fires when the time is reached by a tick, not by a load.
    alarm_arm = 1'b1;
    alarm_hh  = 5'd7;
    alarm_mm  = 6'd30;
    do_set(7, 29, 59);
    cycles_to_tick(20, lat);
    check("alarm_on_tick", 32'(alarm_hit), 32'd1);
    do_set(7, 30, 0);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      tick_cycle();
      if (alarm_hit) hits++;
    end
    check("alarm_not_on_load", 32'(hits), 32'd0);
`else
    hits = 0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      run     = ($urandom_range(9) != 0);
      fmt_12h = $urandom_range(1);
      if ($urandom_range(15) == 0) begin
        set_valid = 1'b1;
        if ($urandom_range(1) == 0) begin
          set_hh = 5'($urandom_range(23));
          set_mm = 6'($urandom_range(59));
          set_ss = 6'($urandom_range(59));
        end else begin
          set_hh = 5'($urandom);
          set_mm = 6'($urandom);
          set_ss = 6'($urandom);
        end
      end else begin
        set_valid = 1'b0;
      end
`ifdef DIGITAL_CLOCK_ALARM_EN
      alarm_arm = $urandom_range(1);
      alarm_hh  = hours;
      alarm_mm  = 6'($urandom_range(59));
`endif
      tick_cycle();
    end
    set_valid = 1'b0;
    run       = 1'b1;
    fmt_12h   = 1'b0;

    // Asynchronous reset mid-count with a set request pending.
    for (int i = 0; i < 7; i++) tick_cycle();
    set_valid = 1'b1;
    set_hh    = 5'd9;
    set_mm    = 6'd9;
    set_ss    = 6'd9;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    set_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycles_to_tick(20, lat);
    check("post_reset_latency", 32'(lat), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
